// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported data memory: p0 (LSU) has priority,
// p1 (DMA/debug) is protected by a starvation counter; illegal accesses are rejected with err.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [2:0]        p0_funct3,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [2:0]        p1_funct3,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_write_en,
  output logic [2:0]        s_type,
  output logic [2:0]        l_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              gnt0, gnt1;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              illegal;
  logic              legal_load;

  logic              p0_rvalid_q, p1_rvalid_q, p0_err_q, p1_err_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (p0_valid && p1_valid) begin
        if (wait_cnt_q == LIMIT) gnt1 = 1'b1;
        else                     gnt0 = 1'b1;
      end else if (p0_valid) begin
        gnt0 = 1'b1;
      end else if (p1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign p0_ready  = gnt0;
  assign p1_ready  = gnt1;
  assign sel_we    = gnt1 ? p1_we     : p0_we;
  assign sel_f3    = gnt1 ? p1_funct3 : p0_funct3;
  assign sel_addr  = gnt1 ? p1_addr   : p0_addr;
  assign sel_wdata = gnt1 ? p1_wdata  : p0_wdata;

  // Size comes from funct3[1:0]; size 11 is never legal, so only the type encodings need extra checks.
  always_comb begin
    illegal = 1'b0;
    if (sel_we && sel_f3 > 3'b010)                             illegal = 1'b1;
    if (!sel_we && (sel_f3 == 3'b011 || sel_f3[2:1] == 2'b11)) illegal = 1'b1;
    if (sel_f3[1:0] == 2'b01 && sel_addr[0])                   illegal = 1'b1;
    if (sel_f3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00)        illegal = 1'b1;
  end

  assign legal_load = !sel_we && !illegal;

  always_comb begin
    mem_write_en = 1'b0;
    s_type       = 3'b010;
    l_type       = 3'b010;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (gnt0 || gnt1) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      if (!illegal) begin
        if (sel_we) begin
          mem_write_en = 1'b1;
          s_type       = sel_f3;
        end else begin
          l_type = sel_f3;
        end
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_valid || gnt1)     wait_cnt_d = 4'd0;
    else if (wait_cnt_q < LIMIT) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q  <= 4'd0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      p0_rvalid_q <= gnt0;
      p1_rvalid_q <= gnt1;
      p0_err_q    <= gnt0 && illegal;
      p1_err_q    <= gnt1 && illegal;
      p0_rdata_q  <= (gnt0 && legal_load) ? mem_rdata : '0;
      p1_rdata_q  <= (gnt1 && legal_load) ? mem_rdata : '0;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte-addressed memory model attached.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p0_ready, p0_we, p0_rvalid, p0_err;
  logic [2:0]  p0_funct3;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_rvalid, p1_err;
  logic [2:0]  p1_funct3;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_write_en;
  logic [2:0]  s_type, l_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_funct3(p0_funct3),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_funct3(p1_funct3),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_write_en(mem_write_en), .s_type(s_type), .l_type(l_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: 16 words, synchronous byte/half/word write, combinational extended read.
  logic [31:0] mem [0:15];
  logic        mem_init_done = 1'b0;
  logic [31:0] rd_word, rd_shift;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
      mem[0] <= 32'h8001_0000;
      mem[1] <= 32'h0000_00F0;
      mem_init_done <= 1'b1;
    end else if (mem_write_en) begin
      case (s_type)
        3'b000:  mem[mem_addr[5:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
        3'b001:  mem[mem_addr[5:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[5:2]] <= mem_wdata;
      endcase
    end
  end

  always_comb begin
    rd_word  = mem[mem_addr[5:2]];
    rd_shift = rd_word >> {mem_addr[1:0], 3'b000};
    case (l_type)
      3'b000:  mem_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  mem_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  mem_rdata = {24'h0, rd_shift[7:0]};
      3'b101:  mem_rdata = {16'h0, rd_shift[15:0]};
      default: mem_rdata = rd_word;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [2:0] f0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic v1, input logic we1, input logic [2:0] f1,
                       input logic [31:0] a1, input logic [31:0] d1);
    p0_valid = v0; p0_we = we0; p0_funct3 = f0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_we = we1; p1_funct3 = f1; p1_addr = a1; p1_wdata = d1;
  endtask

  typedef struct {
    logic        p0v, p0we;
    logic [2:0]  p0f;
    logic [31:0] p0a, p0d;
    logic        p1v, p1we;
    logic [2:0]  p1f;
    logic [31:0] p1a, p1d;
    logic        r0, r1, we;
    logic [31:0] addr;
    logic [2:0]  st, lt;
    logic        rv0, rv1;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    //          p0: v we f  addr   wdata          p1: v we f  addr   wdata      r0 r1 we addr  st lt rv0 rv1 rdata         err
    vecs[0]  = '{0,0,3'd0,32'h00,32'h0,          0,0,3'd0,32'h00,32'h0,      0,0,0,32'h00,3'd2,3'd2,0,0,32'h0,        0};
    vecs[1]  = '{1,1,3'd2,32'h08,32'hDEADBEEF,   0,0,3'd0,32'h00,32'h0,      1,0,1,32'h08,3'd2,3'd2,1,0,32'h0,        0};
    vecs[2]  = '{1,0,3'd2,32'h08,32'h0,          0,0,3'd0,32'h00,32'h0,      1,0,0,32'h08,3'd2,3'd2,1,0,32'hDEADBEEF, 0};
    vecs[3]  = '{0,0,3'd0,32'h00,32'h0,          1,0,3'd1,32'h05,32'h0,      0,1,0,32'h05,3'd2,3'd2,0,1,32'h0,        1};
    vecs[4]  = '{0,0,3'd0,32'h00,32'h0,          1,1,3'd2,32'h0A,32'h1234,   0,1,0,32'h0A,3'd2,3'd2,0,1,32'h0,        1};
    vecs[5]  = '{0,0,3'd0,32'h00,32'h0,          1,0,3'd3,32'h00,32'h0,      0,1,0,32'h00,3'd2,3'd2,0,1,32'h0,        1};
    vecs[6]  = '{1,0,3'd0,32'h04,32'h0,          0,0,3'd0,32'h00,32'h0,      1,0,0,32'h04,3'd2,3'd0,1,0,32'hFFFFFFF0, 0};
    vecs[7]  = '{1,0,3'd4,32'h04,32'h0,          0,0,3'd0,32'h00,32'h0,      1,0,0,32'h04,3'd2,3'd4,1,0,32'h000000F0, 0};
    vecs[8]  = '{1,1,3'd1,32'h03,32'hBEEF,       0,0,3'd0,32'h00,32'h0,      1,0,0,32'h03,3'd2,3'd2,1,0,32'h0,        1};
    vecs[9]  = '{0,0,3'd0,32'h00,32'h0,          1,1,3'd0,32'h10,32'h5A,     0,1,1,32'h10,3'd0,3'd2,0,1,32'h0,        0};
    vecs[10] = '{0,0,3'd0,32'h00,32'h0,          1,0,3'd2,32'h10,32'h0,      0,1,0,32'h10,3'd2,3'd2,0,1,32'h0000005A, 0};
    vecs[11] = '{1,0,3'd1,32'h02,32'h0,          1,0,3'd2,32'h0C,32'h0,      1,0,0,32'h02,3'd2,3'd1,1,0,32'hFFFF8001, 0};
    vecs[12] = '{1,0,3'd5,32'h02,32'h0,          0,0,3'd0,32'h00,32'h0,      1,0,0,32'h02,3'd2,3'd5,1,0,32'h00008001, 0};
    vecs[13] = '{0,0,3'd0,32'h00,32'h0,          1,1,3'd4,32'h00,32'h0,      0,1,0,32'h00,3'd2,3'd2,0,1,32'h0,        1};
    vecs[14] = '{1,1,3'd1,32'h06,32'h1234ABCD,   0,0,3'd0,32'h00,32'h0,      1,0,1,32'h06,3'd1,3'd2,1,0,32'h0,        0};
    vecs[15] = '{1,0,3'd2,32'h04,32'h0,          0,0,3'd0,32'h00,32'h0,      1,0,0,32'h04,3'd2,3'd2,1,0,32'hABCD00F0, 0};

    // Reset state, with both requesters asking so the ready gating is exercised.
    reset = 1'b1;
    drive(1, 1, 3'd2, 32'h08, 32'h1, 1, 1, 3'd2, 32'h0C, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    chk("reset p0_ready", {31'h0, p0_ready}, 32'h0);
    chk("reset p1_ready", {31'h0, p1_ready}, 32'h0);
    chk("reset mem_write_en", {31'h0, mem_write_en}, 32'h0);
    chk("reset rvalids", {30'h0, p0_rvalid, p1_rvalid}, 32'h0);
    chk("reset p0_rdata", p0_rdata, 32'h0);
    chk("reset errs", {30'h0, p0_err, p1_err}, 32'h0);
    @(negedge clk);
    drive(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    reset = 1'b0;

    // Single-cycle vectors, applied back to back.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].p0v, vecs[i].p0we, vecs[i].p0f, vecs[i].p0a, vecs[i].p0d,
            vecs[i].p1v, vecs[i].p1we, vecs[i].p1f, vecs[i].p1a, vecs[i].p1d);
      #1;
      chk($sformatf("v%0d p0_ready", i), {31'h0, p0_ready}, {31'h0, vecs[i].r0});
      chk($sformatf("v%0d p1_ready", i), {31'h0, p1_ready}, {31'h0, vecs[i].r1});
      chk($sformatf("v%0d mem_write_en", i), {31'h0, mem_write_en}, {31'h0, vecs[i].we});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d s_type", i), {29'h0, s_type}, {29'h0, vecs[i].st});
      chk($sformatf("v%0d l_type", i), {29'h0, l_type}, {29'h0, vecs[i].lt});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d p0_rvalid", i), {31'h0, p0_rvalid}, {31'h0, vecs[i].rv0});
      chk($sformatf("v%0d p1_rvalid", i), {31'h0, p1_rvalid}, {31'h0, vecs[i].rv1});
      if (vecs[i].rv0) begin
        chk($sformatf("v%0d p0_rdata", i), p0_rdata, vecs[i].rd);
        chk($sformatf("v%0d p0_err", i), {31'h0, p0_err}, {31'h0, vecs[i].err});
      end
      if (vecs[i].rv1) begin
        chk($sformatf("v%0d p1_rdata", i), p1_rdata, vecs[i].rd);
        chk($sformatf("v%0d p1_err", i), {31'h0, p1_err}, {31'h0, vecs[i].err});
      end
    end

    // Both ports hold loads: p1 wins every fifth cycle once four waits accumulate.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1, 0, 3'd2, 32'h00, 32'h0, 1, 0, 3'd2, 32'h04, 32'h0);
      #1;
      chk($sformatf("starve c%0d p0_ready", i), {31'h0, p0_ready}, {31'h0, (i % 5) != 4});
      chk($sformatf("starve c%0d p1_ready", i), {31'h0, p1_ready}, {31'h0, (i % 5) == 4});
    end

    // Idle: no memory activity, no responses, and the partial wait count is dropped.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
      #1;
      chk($sformatf("idle c%0d mem_write_en", i), {31'h0, mem_write_en}, 32'h0);
      chk($sformatf("idle c%0d mem_addr", i), mem_addr, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("idle c%0d rvalids", i), {30'h0, p0_rvalid, p1_rvalid}, 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 0, 3'd2, 32'h00, 32'h0, 1, 0, 3'd2, 32'h04, 32'h0);
      #1;
      chk($sformatf("restart c%0d p1_ready", i), {31'h0, p1_ready}, {31'h0, i == 4});
    end

    // Reset mid-cycle while a p1 store is pending and a p0 response is showing.
    @(negedge clk);
    drive(1, 0, 3'd2, 32'h04, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("pre-reset p0_rvalid", {31'h0, p0_rvalid}, 32'h1);
    @(negedge clk);
    drive(0, 0, 3'd0, 32'h0, 32'h0, 1, 1, 3'd0, 32'h10, 32'hA5);
    #2;
    reset = 1'b1;
    #1;
    chk("mid-reset p1_ready", {31'h0, p1_ready}, 32'h0);
    chk("mid-reset mem_write_en", {31'h0, mem_write_en}, 32'h0);
    chk("mid-reset p0_rvalid", {31'h0, p0_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    chk("mid-reset p1_rvalid", {31'h0, p1_rvalid}, 32'h0);
    chk("mid-reset no write", mem[4], 32'h0000005A);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("re-sb p1_ready", {31'h0, p1_ready}, 32'h1);
    chk("re-sb mem_write_en", {31'h0, mem_write_en}, 32'h1);
    chk("re-sb s_type", {29'h0, s_type}, 32'h0);
    @(posedge clk);
    #1;
    chk("re-sb p1_rvalid", {31'h0, p1_rvalid}, 32'h1);
    chk("re-sb p1_err", {31'h0, p1_err}, 32'h0);
    chk("re-sb mem word", mem[4], 32'h000000A5);
    @(negedge clk);
    drive(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("re-sb pulse ends", {31'h0, p1_rvalid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
